// File: rtl/term_ctrl_pkg.sv
//------------------------------------------------------------------------------
// term_ctrl_pkg : shared terminal geometry, latch types, control codes,
//                 FSM encodings and cursor arithmetic helpers.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package term_ctrl_pkg;

  localparam int TERM_ROWS = 30;
  localparam int TERM_COLS = 80;

  localparam logic [1:0] DT_CHAR = 2'd0;
  localparam logic [1:0] DT_COL  = 2'd1;
  localparam logic [1:0] DT_ROW  = 2'd2;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  localparam logic [11:0] CELL_LAST = 12'(TERM_ROWS * TERM_COLS - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ESC_R    = 4'd1;
  localparam logic [3:0] ST_ESC_C    = 4'd2;
  localparam logic [3:0] ST_OP1      = 4'd3;
  localparam logic [3:0] ST_OP2      = 4'd4;
  localparam logic [3:0] ST_CLR_ROW  = 4'd5;
  localparam logic [3:0] ST_CLR_COL  = 4'd6;
  localparam logic [3:0] ST_CLR_FILL = 4'd7;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_HI    = 2'd2;
  localparam logic [1:0] PH_LO    = 2'd3;

  function automatic logic [4:0] row_inc(input logic [4:0] row);
    logic [5:0] r;
    r = {1'b0, row} + 6'd1;
    if (r >= 6'(TERM_ROWS)) r = 6'd0;
    return r[4:0];
  endfunction

  // Peripheral auto-advance: {row, col} after a char is written.
  function automatic logic [11:0] advance(input logic [4:0] row, input logic [6:0] col);
    logic [7:0] c;
    logic [4:0] r;
    c = {1'b0, col} + 8'd1;
    r = row;
    if (c >= 8'(TERM_COLS)) begin
      c = 8'd0;
      r = row_inc(row);
    end
    return {r, c[6:0]};
  endfunction

  function automatic logic [4:0] clamp_row(input logic [7:0] b);
    return (b > 8'(TERM_ROWS - 1)) ? 5'(TERM_ROWS - 1) : b[4:0];
  endfunction

  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    return (b > 8'(TERM_COLS - 1)) ? 7'(TERM_COLS - 1) : b[6:0];
  endfunction

  function automatic logic [6:0] tab_col(input logic [6:0] col);
    logic [7:0] t;
    t = ({1'b0, col} | 8'h07) + 8'd1;
    return clamp_col(t);
  endfunction

endpackage

`default_nettype wire

// File: rtl/term_ctrl_if.sv
//------------------------------------------------------------------------------
// term_ctrl_if : host byte valid/ready handshake into the terminal controller.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface term_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

`default_nettype wire

// File: rtl/term_strobe_gen.sv
//------------------------------------------------------------------------------
// term_strobe_gen : one latch op = setup cycle, STB_HI strobe-high cycles,
//                   STB_LO strobe-low cycles; done marks the last low cycle.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module term_strobe_gen
  import term_ctrl_pkg::*;
#(
  parameter int STB_HI = 2,
  parameter int STB_LO = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       start,
  input  wire logic [1:0] op_dtype,
  input  wire logic [7:0] op_data,
  output logic [7:0]      data,
  output logic [1:0]      dtype,
  output logic            dstrobe,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(((STB_HI > STB_LO) ? STB_HI : STB_LO) + 1);
  localparam logic [CW-1:0] HI_LAST = CW'(STB_HI - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(STB_LO - 1);

  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    dtype_q, dtype_d;
  logic          dstrobe_q, dstrobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      data_q    <= 8'd0;
      dtype_q   <= 2'd0;
      dstrobe_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      dtype_q   <= dtype_d;
      dstrobe_q <= dstrobe_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dtype_d   = dtype_q;
    dstrobe_d = 1'b0;
    case (phase_q)
      PH_SETUP: begin
        phase_d   = PH_HI;
        cnt_d     = '0;
        dstrobe_d = 1'b1;
      end
      PH_HI: begin
        if (cnt_q == HI_LAST) begin
          phase_d = PH_LO;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          dstrobe_d = 1'b1;
        end
      end
      PH_LO: begin
        if (cnt_q == LO_LAST) phase_d = PH_IDLE;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      default: ;
    endcase
    // A start on the done cycle chains the next op with no gap.
    if (start) begin
      phase_d   = PH_SETUP;
      cnt_d     = '0;
      data_d    = op_data;
      dtype_d   = op_dtype;
      dstrobe_d = 1'b0;
    end
  end

  assign data    = data_q;
  assign dtype   = dtype_q;
  assign dstrobe = dstrobe_q;
  assign busy    = (phase_q != PH_IDLE);
  assign done    = (phase_q == PH_LO) && (cnt_q == LO_LAST);

endmodule

`default_nettype wire

// File: rtl/term_ctrl.sv
//------------------------------------------------------------------------------
// term_ctrl : byte-stream terminal controller; decodes host bytes into
//             char/column/row latch ops and tracks a shadow cursor.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module term_ctrl
  import term_ctrl_pkg::*;
#(
  parameter int STB_HI     = 2,
  parameter int STB_LO     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  wire logic   ck100,
  input  wire logic   reset,
  term_ctrl_if.slave  rx,
  output logic [7:0]  data,
  output logic [1:0]  dtype,
  output logic        dstrobe,
  output logic [4:0]  currow,
  output logic [6:0]  curcol,
  output logic        busy,
  output logic        clearing
);

  logic [3:0]  state_q, state_d;
  logic        init_q, init_d;
  logic        pend_q, pend_d;
  logic        gap_q, gap_d;
  logic        pair_q, pair_d;
  logic [4:0]  row_q, row_d, op_row_q, op_row_d;
  logic [6:0]  col_q, col_d, op_col_q, op_col_d;
  logic [11:0] cell_q, cell_d;
  logic [1:0]  op_dtype_q, op_dtype_d, st_dtype;
  logic [7:0]  op_data_q, op_data_d, st_data;
  logic        start, sg_busy, sg_done, rdy, acc, is_print, is_op;
  logic [11:0] nxt;

  term_strobe_gen #(.STB_HI(STB_HI), .STB_LO(STB_LO)) u_strobe (
    .clk(ck100), .rst(reset), .start(start), .op_dtype(st_dtype), .op_data(st_data),
    .data(data), .dtype(dtype), .dstrobe(dstrobe), .busy(sg_busy), .done(sg_done)
  );

  always_ff @(posedge ck100 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b1;
      pend_q     <= 1'b0;
      gap_q      <= 1'b0;
      pair_q     <= 1'b0;
      row_q      <= 5'd0;
      col_q      <= 7'd0;
      op_row_q   <= 5'd0;
      op_col_q   <= 7'd0;
      cell_q     <= 12'd0;
      op_dtype_q <= 2'd0;
      op_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      pair_q     <= pair_d;
      row_q      <= row_d;
      col_q      <= col_d;
      op_row_q   <= op_row_d;
      op_col_q   <= op_col_d;
      cell_q     <= cell_d;
      op_dtype_q <= op_dtype_d;
      op_data_q  <= op_data_d;
    end
  end

  assign acc      = rx.rx_valid & rdy;
  assign is_print = (rx.rx_data >= 8'h20) && (rx.rx_data != 8'h7F);
  assign is_op    = is_print || (rx.rx_data == CR) || (rx.rx_data == LF) ||
                    (rx.rx_data == TAB) || ((rx.rx_data == BS) && (col_q != 7'd0));
  assign nxt      = advance(row_q, col_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          if (INIT_CLEAR != 0) state_d = ST_CLR_ROW;
        end else if (acc) begin
          if (is_op)                   state_d = ST_OP1;
          else if (rx.rx_data == FF)  state_d = ST_CLR_ROW;
          else if (rx.rx_data == ESC) state_d = ST_ESC_R;
        end
      end
      ST_ESC_R:    if (acc) state_d = ST_ESC_C;
      ST_ESC_C:    if (acc) state_d = ST_OP1;
      ST_OP1:      if (!pend_q && sg_done) state_d = pair_q ? ST_OP2 : ST_IDLE;
      ST_OP2:      if (sg_done) state_d = ST_IDLE;
      ST_CLR_ROW:  if (!pend_q && sg_done) state_d = ST_CLR_COL;
      ST_CLR_COL:  if (sg_done) state_d = ST_CLR_FILL;
      ST_CLR_FILL: if (sg_done && (cell_q == CELL_LAST)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_d     = (state_q == ST_IDLE) ? 1'b0 : init_q;
    pend_d     = ((state_q == ST_IDLE) || (state_q == ST_ESC_C)) &&
                 ((state_d == ST_OP1) || (state_d == ST_CLR_ROW));
    gap_d      = (state_q == ST_IDLE) && !init_q && acc && (state_d == ST_IDLE);
    pair_d     = pair_q;
    row_d      = row_q;
    col_d      = col_q;
    cell_d     = cell_q;
    op_row_d   = op_row_q;
    op_col_d   = op_col_q;
    op_dtype_d = op_dtype_q;
    op_data_d  = op_data_q;
    start      = 1'b0;
    st_dtype   = op_dtype_q;
    st_data    = op_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!init_q && acc) begin
          pair_d     = 1'b0;
          op_row_d   = row_q;
          op_col_d   = col_q;
          op_dtype_d = DT_COL;
          if (is_print) begin
            op_dtype_d = DT_CHAR;
            op_data_d  = rx.rx_data;
            op_row_d   = nxt[11:7];
            op_col_d   = nxt[6:0];
          end else if (rx.rx_data == LF) begin
            op_dtype_d = DT_ROW;
            op_row_d   = row_inc(row_q);
            op_data_d  = {3'd0, row_inc(row_q)};
          end else begin
            // CR / BS / TAB are all column ops; non-ops leave these unused.
            if (rx.rx_data == CR)       op_col_d = 7'd0;
            else if (rx.rx_data == BS)  op_col_d = col_q - 7'd1;
            else                        op_col_d = tab_col(col_q);
            op_data_d = {1'b0, op_col_d};
          end
        end
      end
      ST_ESC_R: if (acc) op_row_d = clamp_row(rx.rx_data);
      ST_ESC_C: begin
        if (acc) begin
          op_col_d   = clamp_col(rx.rx_data);
          op_dtype_d = DT_ROW;
          op_data_d  = {3'd0, op_row_q};
          pair_d     = 1'b1;
        end
      end
      ST_OP1: begin
        if (pend_q) begin
          start = 1'b1;
          row_d = op_row_q;
          if (!pair_q) col_d = op_col_q;
        end else if (sg_done && pair_q) begin
          start    = 1'b1;
          st_dtype = DT_COL;
          st_data  = {1'b0, op_col_q};
          col_d    = op_col_q;
        end
      end
      ST_CLR_ROW: begin
        if (pend_q) begin
          start    = 1'b1;
          st_dtype = DT_ROW;
          st_data  = 8'd0;
          row_d    = 5'd0;
        end else if (sg_done) begin
          start    = 1'b1;
          st_dtype = DT_COL;
          st_data  = 8'd0;
          col_d    = 7'd0;
        end
      end
      ST_CLR_COL, ST_CLR_FILL: begin
        if (sg_done && !((state_q == ST_CLR_FILL) && (cell_q == CELL_LAST))) begin
          start    = 1'b1;
          st_dtype = DT_CHAR;
          st_data  = CLEAR_CHAR;
          row_d    = nxt[11:7];
          col_d    = nxt[6:0];
          cell_d   = (state_q == ST_CLR_COL) ? 12'd0 : cell_q + 12'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rdy      = ((state_q == ST_IDLE) && !init_q && !gap_q) ||
               (state_q == ST_ESC_R) || (state_q == ST_ESC_C);
    busy     = !((state_q == ST_IDLE) || (state_q == ST_ESC_R) || (state_q == ST_ESC_C)) || sg_busy;
    clearing = (state_q == ST_CLR_ROW) || (state_q == ST_CLR_COL) || (state_q == ST_CLR_FILL);
  end

  assign rx.rx_ready = rdy;
  assign currow      = row_q;
  assign curcol      = col_q;

endmodule

`default_nettype wire

// File: tb/tb_term_ctrl.sv
//------------------------------------------------------------------------------
// tb_term_ctrl : scoreboard bench for term_ctrl; expected latch ops are queued
//                by the stimulus and checked by a monitor on each dstrobe rise.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_term_ctrl;

  typedef struct packed {
    logic [1:0] dt;
    logic [7:0] d;
    logic       clr;
  } exp_t;

  logic       ck100 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data;
  logic [1:0] dtype;
  logic       dstrobe, busy, clearing;
  logic [4:0] currow;
  logic [6:0] curcol;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic prev_stb = 1'b0;

  term_ctrl_if rxif ();

  term_ctrl #(.STB_HI(2), .STB_LO(1), .INIT_CLEAR(1)) dut (
    .ck100(ck100), .reset(reset), .rx(rxif.slave), .data(data), .dtype(dtype),
    .dstrobe(dstrobe), .currow(currow), .curcol(curcol), .busy(busy), .clearing(clearing)
  );

  always #5 ck100 = ~ck100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] dt, input logic [7:0] d, input logic clr);
    exp_t e;
    e.dt = dt; e.d = d; e.clr = clr;
    q.push_back(e);
  endtask

  task automatic push_clear();
    push(2'd2, 8'h00, 1'b1);
    push(2'd1, 8'h00, 1'b1);
    for (int i = 0; i < 2400; i++) push(2'd0, 8'h20, 1'b1);
  endtask

  // Monitor: every rising dstrobe must match the head of the queue.
  initial begin
    forever begin
      @(negedge ck100);
      if (dstrobe && !prev_stb) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'(data), 32'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latch_op", 32'({dtype, data, clearing}), 32'({e.dt, e.d, e.clr}));
        end
      end
      prev_stb = dstrobe;
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge ck100);
    rxif.rx_data  = b;
    rxif.rx_valid = 1'b1;
    n = 0;
    while (!rxif.rx_ready && n < 20000) begin
      @(negedge ck100);
      n++;
    end
    chk("rx_ready_seen", 32'(rxif.rx_ready), 32'd1);
    @(posedge ck100);
    #1;
    rxif.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max, output int cyc);
    cyc = 0;
    @(negedge ck100);
    while (!(rxif.rx_ready && !busy) && cyc < max) begin
      @(negedge ck100);
      cyc++;
    end
    chk(nm, 32'(rxif.rx_ready && !busy), 32'd1);
  endtask

  task automatic esc_seq(input logic [7:0] r, input logic [7:0] c,
                         input logic [7:0] er, input logic [7:0] ec);
    int cy;
    push(2'd2, er, 1'b0);
    push(2'd1, ec, 1'b0);
    send(8'h1B);
    send(r);
    send(c);
    wait_idle("esc_idle", 100, cy);
  endtask

  task automatic cursor(input string nm, input logic [4:0] r, input logic [6:0] c);
    chk(nm, 32'({currow, curcol}), 32'({r, c}));
  endtask

  initial begin
    int         cy;
    int         accepts;
    logic [5:0] pat, rdyp;
    logic       busy_seen;
    rxif.rx_data  = 8'h00;
    rxif.rx_valid = 1'b0;

    repeat (3) @(negedge ck100);
    chk("rst_dstrobe", 32'(dstrobe), 32'd0);
    chk("rst_data_dtype", 32'({data, dtype}), 32'd0);
    chk("rst_rx_ready", 32'(rxif.rx_ready), 32'd0);
    cursor("rst_cursor", 5'd0, 7'd0);
    chk("rst_busy_clearing", 32'({busy, clearing}), 32'd0);

    push_clear();
    reset = 1'b0;
    wait_idle("init_clear_done", 12000, cy);
    chk("init_clear_cycles", 32'(cy >= 9600 && cy <= 9620), 32'd1);
    cursor("clear_cursor", 5'd0, 7'd0);
    chk("clear_queue_drained", 32'(q.size()), 32'd0);

    // 'A': strobe high in cycles N+2, N+3; ready again at N+5.
    push(2'd0, 8'h41, 1'b0);
    send(8'h41);
    for (int i = 0; i < 6; i++) begin
      @(negedge ck100);
      pat[i]  = dstrobe;
      rdyp[i] = rxif.rx_ready;
    end
    chk("char_strobe_timing", 32'(pat), 32'(6'b001100));
    chk("char_ready_timing", 32'(rdyp), 32'(6'b100000));
    cursor("char_cursor", 5'd0, 7'd1);

    esc_seq(8'h25, 8'h63, 8'd29, 8'd79);
    cursor("esc_clamp_cursor", 5'd29, 7'd79);
    push(2'd0, 8'h42, 1'b0);
    send(8'h42);
    wait_idle("wrap_idle", 100, cy);
    cursor("wrap_cursor", 5'd0, 7'd0);

    esc_seq(8'd29, 8'd5, 8'd29, 8'd5);
    push(2'd2, 8'd0, 1'b0);
    send(8'h0A);
    wait_idle("lf_idle", 100, cy);
    cursor("lf_wrap_cursor", 5'd0, 7'd5);

    push(2'd1, 8'd8, 1'b0);
    send(8'h09);
    wait_idle("tab_idle", 100, cy);
    cursor("tab5_cursor", 5'd0, 7'd8);

    esc_seq(8'd0, 8'd77, 8'd0, 8'd77);
    push(2'd1, 8'd79, 1'b0);
    send(8'h09);
    wait_idle("tab77_idle", 100, cy);
    cursor("tab77_cursor", 5'd0, 7'd79);

    push(2'd1, 8'd0, 1'b0);
    send(8'h0D);
    wait_idle("cr_idle", 100, cy);
    cursor("cr_cursor", 5'd0, 7'd0);

    // BS at column 0: no op, ready back one cycle after the accept.
    send(8'h08);
    @(negedge ck100);
    pat[0] = rxif.rx_ready;
    busy_seen = busy;
    @(negedge ck100);
    pat[1] = rxif.rx_ready;
    busy_seen = busy_seen | busy;
    chk("bs0_ready", 32'(pat[1:0]), 32'(2'b10));
    chk("bs0_busy", 32'(busy_seen), 32'd0);
    cursor("bs0_cursor", 5'd0, 7'd0);

    esc_seq(8'd3, 8'd10, 8'd3, 8'd10);
    push(2'd1, 8'd9, 1'b0);
    send(8'h08);
    wait_idle("bs_idle", 100, cy);
    cursor("bs_cursor", 5'd3, 7'd9);

    // Hold 0x07: consumed repeatedly, never busy, cursor untouched.
    @(negedge ck100);
    rxif.rx_data  = 8'h07;
    rxif.rx_valid = 1'b1;
    accepts   = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxif.rx_ready) accepts++;
      busy_seen = busy_seen | busy;
      @(negedge ck100);
    end
    rxif.rx_valid = 1'b0;
    chk("bel_accepts", 32'(accepts >= 3), 32'd1);
    chk("bel_busy", 32'(busy_seen), 32'd0);
    cursor("bel_cursor", 5'd3, 7'd9);

    // Reset in the middle of a strobe.
    push(2'd0, 8'h43, 1'b0);
    send(8'h43);
    cy = 0;
    while (!dstrobe && cy < 20) begin
      @(negedge ck100);
      cy++;
    end
    chk("mid_op_strobe_seen", 32'(dstrobe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dstrobe", 32'(dstrobe), 32'd0);
    chk("async_rst_outputs", 32'({data, dtype, rxif.rx_ready, busy, clearing}), 32'd0);
    cursor("async_rst_cursor", 5'd0, 7'd0);
    q.delete();
    push_clear();
    repeat (2) @(negedge ck100);
    reset = 1'b0;
    wait_idle("reclear_done", 12000, cy);
    cursor("reclear_cursor", 5'd0, 7'd0);
    chk("final_queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/term_ctrl.md
Name: term_ctrl

Overview:
- Byte-stream terminal controller. Drives the character terminal peripheral's latch interface (data, dstrobe, dtype).
- Accepts host bytes over a valid/ready handshake. Interprets printable codes and a small control-code set (CR, LF, BS, TAB, FF, ESC row/col).
- Sequences the resulting char, column and row latch strobes.
- Keeps a shadow cursor, because the peripheral powers up at row 15, col 40, not 0,0.

Parameters:
- STB_HI, 2, ck100 cycles dstrobe is held high per latch op (>=1).
- STB_LO, 1, ck100 cycles dstrobe is held low after the high phase (>=1).
- INIT_CLEAR, 1, when 1, a full clear sequence runs automatically on reset release.

Ports:
- ck100  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller can accept a byte; a byte transfers when rx_valid & rx_ready at a ck100 edge
- data  out  8  latch data to the peripheral
- dtype  out  2  0 = char, 1 = column, 2 = row
- dstrobe  out  1  latch strobe; the peripheral captures on its rising edge
- currow  out  5  shadow cursor row, 0..29
- curcol  out  7  shadow cursor column, 0..79
- busy  out  1  latch op or multi-op sequence in progress
- clearing  out  1  clear sequence in progress

Behaviour:
- Reset values: dstrobe=0, dtype=0, data=0, rx_ready=0, currow=0, curcol=0, busy=0, clearing=0.
- Reset asserted mid-op: dstrobe drops to 0 immediately and the op is aborted.
- After release: if INIT_CLEAR, enter CLR; else IDLE.
- Latch op timing, per op:
  - 1 setup cycle with data/dtype stable and dstrobe=0.
  - STB_HI cycles with dstrobe=1.
  - STB_LO cycles with dstrobe=0.
  - data/dtype hold for the whole op.
  - Total 1+STB_HI+STB_LO cycles; defaults give 4.
- IDLE: rx_ready=1 and busy=0. A byte accepted at edge N gives rx_ready=0 from N. The first op's setup cycle is N+1.
- Control-code decode:
  - 0x20-0x7E, 0x80-0xFF: char op (dtype 0, data=byte). Then curcol+1. At col 79 → col 0, row+1, and row 29 wraps to 0. This mirrors the peripheral's auto-advance.
  - 0x0D CR: curcol=0, column op with data 0.
  - 0x0A LF: row+1, 29→0; row op with the new row. Column is unchanged.
  - 0x08 BS: if curcol>0, curcol-1 and column op. At col 0, no op; return to IDLE next cycle.
  - 0x09 TAB: curcol=min((curcol|7)+1, 79), column op.
  - 0x0C FF: enter CLR.
  - 0x1B ESC: go to ESC_R, rx_ready=1. The next byte is the row, clamped to 29. Go to ESC_C, rx_ready=1. The next byte is the column, clamped to 79. Then row op followed by column op. Any byte value is accepted as an ESC argument.
  - All other codes below 0x20, and 0x7F: consumed, no op, back to IDLE.
- CLR: clearing=1.
  - Ops in order: row 0, column 0, then 2400 char ops with data 0x20.
  - The shadow cursor advances with each char op; after the last one it is back at 0,0.
  - Then IDLE. Duration with defaults: 2402*4 = 9608 cycles.
- Shadow currow/curcol update on the setup cycle of the op that changes them. ESC row/col update at their own ops.
- States: IDLE, ESC_R, ESC_C, OP1, OP2 (second op of a pair), CLR_ROW, CLR_COL, CLR_FILL.
- busy=1 in every state except IDLE, ESC_R and ESC_C.
- Cell counter: 12-bit, counts 0..2399. Row/col arithmetic is done at full width before clamp or wrap, with no truncation aliasing.

Decomposition:
- Shared include file term_defs.vh holds:
  - TERM_ROWS=30, TERM_COLS=80
  - DT_CHAR=0, DT_COL=1, DT_ROW=2
  - control codes CR, LF, BS, TAB, FF, ESC
  - CLEAR_CHAR=8'h20
- Sub-module term_strobe_gen:
  - Inputs: start pulse, op dtype/data.
  - Outputs: data, dtype, dstrobe, busy, one-cycle done on the last low cycle.
  - Implements the STB_HI/STB_LO timing.
- term_ctrl keeps the decode FSM, shadow cursor and clear counter.

Test Plan:
- INIT_CLEAR=1, reset release → 2402 ops (row 0, col 0, then 2400× dtype0 data 0x20); clearing=1 throughout. Then currow=0, curcol=0, rx_ready=1 at cycle ≈9608.
- After clear, send 0x41 'A' → exactly one rising dstrobe with dtype=0, data=0x41. dstrobe high for 2 cycles starting N+2. curcol=1; rx_ready high again by N+5.
- ESC, 0x25, 0x63 (row 37, col 99) → row op data 29, then column op data 79. currow=29, curcol=79. Then 'B' → char op, cursor wraps to 0,0.
- At row 29: LF → row op data 0. At col 0: BS → no dstrobe, rx_ready back high next cycle. TAB from col 5 → column op data 8; TAB from col 77 → data 79.
- Assert reset while dstrobe=1 during an op → dstrobe=0 asynchronously, all outputs at reset values. After release the clear restarts from row op 0.
- Hold rx_valid with 0x07 → byte consumed, no dstrobe, busy stays 0.
